traffic_countdown: RTL and testbench

Countdown display stage that sits directly downstream of the traffic light controller. It consumes the controller's one-hot `red`/`yellow`/`green` lines and tracks the cycles remaining in the current light phase. It converts that count to two BCD digits and drives a time-multiplexed two-digit 7-segment display. It also flags illegal light encodings and phases that outrun their configured duration.

---
 rtl/traffic_countdown_if.sv | 19 +
 rtl/traffic_countdown.sv | 130 +++++++++++++
 tb/tb_traffic_countdown.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_countdown_if.sv
// Light lines from the traffic controller into the countdown stage.
// The controller drives them; the countdown stage only observes.
interface traffic_countdown_if;
    logic red;
    logic yellow;
    logic green;

    modport master (
        output red,
        output yellow,
        output green
    );

    modport slave (
        input red,
        input yellow,
        input green
    );
endinterface

// File: rtl/traffic_countdown.sv
// Phase countdown with BCD split and a scanned two-digit 7-seg display.
// Flags non-one-hot light codes and phases that outlast their time.
module traffic_countdown #(
    parameter int RED_TIME    = 15,
    parameter int YELLOW_TIME = 4,
    parameter int GREEN_TIME  = 11,
    parameter int REFRESH     = 1000
) (
    input  logic                clk,
    input  logic                rst,
    traffic_countdown_if.slave  lights,
    output logic [6:0]          remain,
    output logic [3:0]          tens,
    output logic [3:0]          ones,
    output logic [6:0]          seg,
    output logic [1:0]          an,
    output logic                fault,
    output logic                overrun
);

    localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [CW-1:0] SCAN_TOP = CW'(REFRESH - 1);

    logic [2:0]    light;
    logic [2:0]    light_q;
    logic          one_hot;
    logic [6:0]    load;
    logic [CW-1:0] scan_cnt;
    logic          digit_sel;

    assign light = {lights.red, lights.yellow, lights.green};

    always_comb begin
        one_hot = 1'b0;
        load    = '0;
        unique case (light)
            3'b100: begin
                one_hot = 1'b1;
                load    = 7'(RED_TIME - 1);
            end
            3'b010: begin
                one_hot = 1'b1;
                load    = 7'(YELLOW_TIME - 1);
            end
            3'b001: begin
                one_hot = 1'b1;
                load    = 7'(GREEN_TIME - 1);
            end
            default: begin
                one_hot = 1'b0;
                load    = '0;
            end
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // A bad code overwrites light_q, so the next good code reloads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            light_q <= '0;
            remain  <= '0;
            fault   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            light_q <= light;
            fault   <= ~one_hot;
            overrun <= 1'b0;
            if (!one_hot) begin
                remain <= '0;
            end else if (light != light_q) begin
                remain <= load;
            end else if (remain != 7'd0) begin
                remain <= remain - 7'd1;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens      <= '0;
            ones      <= '0;
            scan_cnt  <= '0;
            digit_sel <= 1'b0;
            seg       <= '0;
            an        <= '0;
        end else begin
            tens <= 4'(remain / 7'd10);
            ones <= 4'(remain % 7'd10);
            if (scan_cnt == SCAN_TOP) begin
                scan_cnt  <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (fault) begin
                seg <= '0;
                an  <= 2'b00;
            end else if (digit_sel) begin
                if (tens == 4'd0) begin
                    seg <= '0;
                    an  <= 2'b00;
                end else begin
                    seg <= seg7(tens);
                    an  <= 2'b10;
                end
            end else begin
                seg <= seg7(ones);
                an  <= 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_traffic_countdown.sv
// Randomised bench for traffic_countdown against a phase-age model,
// plus literal expectations for the documented scenarios.
module tb_traffic_countdown;
    localparam int RT = 15;
    localparam int YT = 2;
    localparam int GT = 3;
    localparam int RF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] remain;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [1:0] an;
    logic       fault;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    traffic_countdown_if lif ();

    traffic_countdown #(
        .RED_TIME    (RT),
        .YELLOW_TIME (YT),
        .GREEN_TIME  (GT),
        .REFRESH     (RF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lights  (lif),
        .remain  (remain),
        .tens    (tens),
        .ones    (ones),
        .seg     (seg),
        .an      (an),
        .fault   (fault),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic [2:0] m_prev;
    int         m_age;
    int         m_rem;
    int         m_tens;
    int         m_ones;
    int         m_n;
    bit         m_fault;
    bit         m_ovr;
    bit         m_sel;
    logic [6:0] m_seg;
    logic [1:0] m_an;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int ptime(input logic [2:0] l);
        case (l)
            3'b100:  return RT;
            3'b010:  return YT;
            3'b001:  return GT;
            default: return 0;
        endcase
    endfunction

    task automatic m_reset();
        m_prev  = '0;
        m_age   = 0;
        m_rem   = 0;
        m_tens  = 0;
        m_ones  = 0;
        m_n     = 0;
        m_fault = 0;
        m_ovr   = 0;
        m_sel   = 0;
        m_seg   = '0;
        m_an    = '0;
    endtask

    // Phase age k gives remain = max(T-1-k, 0); overrun once k >= T.
    task automatic m_edge();
        logic [2:0] l;
        int t;
        l = {lif.red, lif.yellow, lif.green};
        if (m_fault || (m_sel && m_tens == 0)) begin
            m_seg = '0;
            m_an  = 2'b00;
        end else if (m_sel) begin
            m_seg = segtab[m_tens];
            m_an  = 2'b10;
        end else begin
            m_seg = segtab[m_ones];
            m_an  = 2'b01;
        end
        m_tens = m_rem / 10;
        m_ones = m_rem % 10;
        m_n++;
        m_sel = ((m_n / RF) % 2) == 1;
        m_ovr = 0;
        if ($countones(l) != 1) begin
            m_fault = 1;
            m_rem   = 0;
            m_age   = 0;
        end else begin
            m_fault = 0;
            t = ptime(l);
            if (l != m_prev) m_age = 0;
            else if (m_age < 1000) m_age++;
            m_rem = (t - 1 - m_age > 0) ? t - 1 - m_age : 0;
            m_ovr = (m_age >= t);
        end
        m_prev = l;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst) m_reset();
            else m_edge();
            @(negedge clk);
            if (!rst) m_reset();
            check("remain", remain, m_rem);
            check("tens", tens, m_tens);
            check("ones", ones, m_ones);
            check("seg", seg, m_seg);
            check("an", an, m_an);
            check("fault", fault, m_fault);
            check("overrun", overrun, m_ovr);
        end
    end

    task automatic step(input logic [2:0] l);
        {lif.red, lif.yellow, lif.green} = l;
        @(posedge clk);
        #2;
    endtask

    int seq_rem [6] = '{1, 0, 2, 1, 0, 14};
    logic [2:0] seq_l [6] = '{3'b010, 3'b010, 3'b001,
                              3'b001, 3'b001, 3'b100};
    int ov_rem [5] = '{1, 0, 0, 0, 0};
    bit ov_exp [5] = '{0, 0, 1, 1, 1};

    initial begin
        int blank_bad;
        int saw_blank;
        logic [2:0] l;
        int len;
        {lif.red, lif.yellow, lif.green} = 3'b000;
        #3 rst = 1'b0;
        #1;
        check("rst_remain", remain, 0);
        check("rst_seg_an", {seg, an}, 0);
        check("rst_fault", {fault, overrun}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        step(3'b000);
        check("zero_fault", fault, 1);
        check("zero_remain", remain, 0);
        step(3'b000);
        check("zero_blank", {seg, an}, 0);
        step(3'b100);
        check("red_load", remain, RT - 1);
        check("red_fault_clr", fault, 0);

        blank_bad = 0;
        saw_blank = 0;
        for (int i = 0; i < RT - 1; i++) begin
            step(3'b100);
            if (remain <= 7 && an == 2'b10) blank_bad++;
            if (remain <= 7 && an == 2'b00) saw_blank++;
        end
        check("red_zero", remain, 0);
        check("lead_zero_bad", blank_bad, 0);
        check("lead_zero_seen", saw_blank > 0, 1);

        for (int i = 0; i < 6; i++) begin
            step(seq_l[i]);
            check("seq_remain", remain, seq_rem[i]);
            check("seq_overrun", overrun, 0);
        end

        for (int i = 0; i < 5; i++) begin
            step(3'b010);
            check("ov_remain", remain, ov_rem[i]);
            check("ov_pulse", overrun, ov_exp[i]);
        end
        step(3'b001);
        check("ov_reload", remain, GT - 1);
        check("ov_clear", overrun, 0);

        step(3'b110);
        check("bad_fault", fault, 1);
        check("bad_remain", remain, 0);
        step(3'b110);
        check("bad_blank", {seg, an}, 0);
        step(3'b001);
        check("bad_clear", fault, 0);
        check("bad_reload", remain, GT - 1);

        step(3'b001);
        step(3'b001);
        check("expire_zero", remain, 0);
        step(3'b111);
        check("prio_fault", fault, 1);
        check("prio_no_ovr", overrun, 0);

        step(3'b010);
        check("mid_yellow", remain, YT - 1);
        #1 rst = 1'b0;
        #1;
        check("async_remain", remain, 0);
        check("async_bcd", {tens, ones}, 0);
        check("async_disp", {seg, an}, 0);
        check("async_flags", {fault, overrun}, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(3'b100);
        check("post_rst_red", remain, RT - 1);

        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                l = 3'($urandom_range(0, 7));
                len = $urandom_range(1, 2);
            end else begin
                case ($urandom_range(0, 2))
                    0:       l = 3'b100;
                    1:       l = 3'b010;
                    default: l = 3'b001;
                endcase
                len = $urandom_range(1, 20);
            end
            for (int j = 0; j < len; j++) step(l);
            if ($urandom_range(0, 39) == 0) begin
                #1 rst = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
            end
        end

        @(posedge clk);
        #7;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
